// File: rtl/sync_fifo_core.sv
// ============================================================================
// sync_fifo_core : single-clock FIFO with occupancy, almost flags, ovf/udf
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo_core #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_wren,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic              o_ovf,
  output logic              o_udf
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rddata_q, rddata_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_ok, rd_ok;

  // Flags come straight from the registered count so they track o_count.
  assign o_full      = (count_q == FULL_CNT);
  assign o_empty     = (count_q == '0);
  assign o_alm_full  = (count_q >= AF_CNT);
  assign o_alm_empty = (count_q <= AE_CNT);
  assign o_count     = count_q;
  assign o_rddata    = rddata_q;
  assign o_ovf       = ovf_q;
  assign o_udf       = udf_q;

  always_comb begin
    wr_ok    = i_wren && !o_full;
    rd_ok    = i_rden && !o_empty;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rddata_d = rddata_q;
    ovf_d    = i_wren && o_full;
    udf_d    = i_rden && o_empty;

    if (wr_ok) begin
      wptr_d = wptr_q + ADDR_W'(1);
    end
    if (rd_ok) begin
      rptr_d   = rptr_q + ADDR_W'(1);
      rddata_d = mem_q[rptr_q];
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rddata_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rddata_q <= rddata_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem_q[wptr_q] <= i_wrdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_core.sv
// ============================================================================
// tb_sync_fifo_core : directed scoreboard bench for sync_fifo_core
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_wrdata;
  logic       i_wren;
  logic       i_rden;
  logic [7:0] o_rddata;
  logic       o_full;
  logic       o_empty;
  logic       o_alm_full;
  logic       o_alm_empty;
  logic [4:0] o_count;
  logic       o_ovf;
  logic       o_udf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  sync_fifo_core #(
    .DATA_W  (8),
    .DEPTH   (16),
    .AF_LEVEL(12),
    .AE_LEVEL(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_wrdata   (i_wrdata),
    .i_wren     (i_wren),
    .i_rden     (i_rden),
    .o_rddata   (o_rddata),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_alm_full (o_alm_full),
    .o_alm_empty(o_alm_empty),
    .o_count    (o_count),
    .o_ovf      (o_ovf),
    .o_udf      (o_udf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive strobes, take the edge, leave outputs settled for checks.
  task automatic cyc(input logic wr, input logic rd, input logic [7:0] data);
    i_wren   = wr;
    i_rden   = rd;
    i_wrdata = data;
    @(posedge clk);
    #1;
    i_wren = 1'b0;
    i_rden = 1'b0;
  endtask

  // Monitor: a read presented at an edge while non-empty yields data one cycle later.
  always @(posedge clk) begin
    logic took;
    took = i_rden && !o_empty && !reset;
    #1;
    if (took) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rddata: got 0x%0h with no read expected at %0t", o_rddata, $time);
      end else begin
        check("rddata", {24'h0, o_rddata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [7:0] r;
    reset    = 1'b1;
    i_wren   = 1'b0;
    i_rden   = 1'b0;
    i_wrdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", o_count, 0);
    check("rst_empty", o_empty, 1);
    check("rst_alm_empty", o_alm_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_alm_full", o_alm_full, 0);
    check("rst_ovf", o_ovf, 0);
    check("rst_udf", o_udf, 0);
    check("rst_rddata", o_rddata, 0);
    reset = 1'b0;

    // 1: fill 0x01..0x10 and watch flag thresholds
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      check("t1_count", o_count, i);
      check("t1_alm_full", o_alm_full, (i >= 12) ? 1 : 0);
      check("t1_full", o_full, (i == 16) ? 1 : 0);
      check("t1_alm_empty", o_alm_empty, (i <= 4) ? 1 : 0);
    end

    // 2: overflow write, then drain in order
    cyc(1'b1, 1'b0, 8'hAA);
    check("t2_ovf", o_ovf, 1);
    check("t2_count", o_count, 16);
    cyc(1'b0, 1'b0, 8'h00);
    check("t2_ovf_clear", o_ovf, 0);
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(8'(i));
      cyc(1'b0, 1'b1, 8'h00);
      check("t2_count", o_count, 16 - i);
    end
    check("t2_empty", o_empty, 1);

    // 3: underflow read, then simultaneous write/read while empty
    cyc(1'b0, 1'b1, 8'h00);
    check("t3_udf", o_udf, 1);
    check("t3_rddata_hold", o_rddata, 8'h10);
    check("t3_count", o_count, 0);
    cyc(1'b0, 1'b0, 8'h00);
    check("t3_udf_clear", o_udf, 0);
    cyc(1'b1, 1'b1, 8'h55);
    check("t3_count_wr", o_count, 1);
    check("t3_udf_wr", o_udf, 1);
    check("t3_empty", o_empty, 0);
    check("t3_rddata_hold2", o_rddata, 8'h10);
    exp_q.push_back(8'h55);
    cyc(1'b0, 1'b1, 8'h00);
    check("t3_drain", o_count, 0);

    // 4: steady-state streaming at fill level 8 across pointer wrap
    d = 8'h00;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, d);
      d++;
    end
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(r);
      r++;
      cyc(1'b1, 1'b1, d);
      d++;
      check("t4_count", o_count, 8);
      check("t4_ovf", o_ovf, 0);
      check("t4_udf", o_udf, 0);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(r);
      r++;
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("t4_empty", o_empty, 1);

    // 5: reset in the middle of a write burst
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'h80 + 8'(i));
    check("t5_count_pre", o_count, 10);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 8'h99);
    reset = 1'b0;
    check("t5_count", o_count, 0);
    check("t5_empty", o_empty, 1);
    check("t5_rddata", o_rddata, 0);
    cyc(1'b1, 1'b0, 8'h3C);
    check("t5_count_wr", o_count, 1);
    exp_q.push_back(8'h3C);
    cyc(1'b0, 1'b1, 8'h00);
    check("t5_rddata_3c", o_rddata, 8'h3C);

    // 6: simultaneous write/read while full: read wins, write dropped
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'hC0 + 8'(i));
    check("t6_full", o_full, 1);
    exp_q.push_back(8'hC0);
    cyc(1'b1, 1'b1, 8'hEE);
    check("t6_count", o_count, 15);
    check("t6_ovf", o_ovf, 1);
    check("t6_full_clear", o_full, 0);
    for (int i = 1; i < 16; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("t6_empty", o_empty, 1);

    repeat (2) @(posedge clk);
    #2;
    check("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
